// File: rtl/seq_tx_pkg.sv
// ============================================================================
// Module      : seq_tx_pkg
// Description : Shared types and defaults for the serial pattern transmitter:
//               FSM state encoding, default pattern, gap and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_tx_pkg;

  // Default build: 5-bit pattern, two idle zeros between repetitions
  localparam int unsigned DEFAULT_WIDTH   = 5;
  localparam int unsigned DEFAULT_GAP     = 2;
  localparam int unsigned DEFAULT_CNT_W   = 4;
  localparam logic [4:0]  DEFAULT_PATTERN = 5'b10010;

  // Gap counter is sized for the largest supported gap (15)
  localparam int unsigned GAP_CNT_W = 4;

  // Transmitter states, explicitly two bits wide
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : seq_tx_pkg

`default_nettype wire

// File: rtl/seq_tx_shifter.sv
// ============================================================================
// Module      : seq_tx_shifter
// Description : Loadable MSB-first shift register holding the bits of the
//               current pattern that are still to be sent. The MSB itself is
//               driven by the parent at load time, so a load stores the
//               pattern pre-shifted by one and arms WIDTH-1 remaining bits.
//               last_bit_o is high while the bit currently on the line is
//               the final one of the pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tx_shifter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  output logic             next_bit_o,
  output logic             last_bit_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Next-state: load takes priority over shift, otherwise hold
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_val_i << 1;
      cnt_d = CW'(WIDTH - 1);
    end else if (shift_i) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Shift register and remaining-bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign next_bit_o = sr_q[WIDTH-1];
  assign last_bit_o = (cnt_q == '0);

endmodule : seq_tx_shifter

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter. Sends a latched WIDTH-bit pattern
//               MSB-first on j, repeated count times with GAP idle zeros in
//               between, then pulses done for one cycle. All outputs are
//               registered (Moore style).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GAP   = DEFAULT_GAP,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] count,
  output logic             j,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam bit                   HAS_GAP  = (GAP > 0);
  localparam logic [GAP_CNT_W-1:0] GAP_INIT = HAS_GAP ? GAP_CNT_W'(GAP - 1) : '0;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0]     rep_q, rep_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 j_q, j_d;
  logic                 frame_q, frame_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 sh_load;
  logic [WIDTH-1:0]     sh_load_val;
  logic                 sh_shift;
  logic                 sh_next_bit;
  logic                 sh_last_bit;

  seq_tx_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sh_load),
    .load_val_i (sh_load_val),
    .shift_i    (sh_shift),
    .next_bit_o (sh_next_bit),
    .last_bit_o (sh_last_bit)
  );

  // Next-state and next-output logic; outputs default to the idle values
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    j_d         = 1'b0;
    frame_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sh_load     = 1'b0;
    sh_load_val = pat_q;
    sh_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d = pattern;
          rep_d = count;
          if (count != '0) begin
            // First bit goes out on the accepting edge itself
            sh_load     = 1'b1;
            sh_load_val = pattern;
            j_d         = pattern[WIDTH-1];
            frame_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        if (!sh_last_bit) begin
          sh_shift = 1'b1;
          j_d      = sh_next_bit;
          frame_d  = 1'b1;
          busy_d   = 1'b1;
        end else begin
          rep_d = rep_q - CNT_W'(1);
          if (rep_q != CNT_W'(1)) begin
            busy_d = 1'b1;
            if (HAS_GAP) begin
              gap_d   = GAP_INIT;
              state_d = ST_GAP;
            end else begin
              // Back-to-back repetition: reload without a bubble
              sh_load = 1'b1;
              j_d     = pat_q[WIDTH-1];
              frame_d = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          sh_load = 1'b1;
          j_d     = pat_q[WIDTH-1];
          frame_d = 1'b1;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      j_q     <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      j_q     <= j_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign j     = j_q;
  assign frame = frame_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : seq_pattern_tx

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Scoreboard bench for seq_pattern_tx. Two instances share the
//               clock and reset: one with GAP=2, one with GAP=0. Expected
//               per-cycle output words {j,frame,busy,done} are queued from
//               hand-written strings ('1'/'0' pattern bit, '_' gap zero, a
//               done word appended); monitors pop whenever an instance shows
//               any non-idle output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start2, start0;
  logic [W-1:0] pat2, pat0;
  logic [3:0]   cnt2, cnt0;
  logic         j2, f2, b2, d2;
  logic         j0, f0, b0, d0;

  int checks = 0;
  int errors = 0;

  logic [3:0] q2[$];
  logic [3:0] q0[$];
  logic [3:0] g2, e2, g0, e0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .GAP(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pat2), .count(cnt2),
    .j(j2), .frame(f2), .busy(b2), .done(d2)
  );

  seq_pattern_tx #(.WIDTH(W), .GAP(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pat0), .count(cnt0),
    .j(j0), .frame(f0), .busy(b0), .done(d0)
  );

  // Monitor for the GAP=2 instance
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      g2 = {j2, f2, b2, d2};
      if (g2 !== 4'b0000) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL mon_gap2 unexpected output jfbd=%b required none t=%0t", g2, $time);
        end else begin
          e2 = q2.pop_front();
          if (g2 !== e2) begin
            errors++;
            $display("FAIL mon_gap2 jfbd=%b required %b t=%0t", g2, e2, $time);
          end
        end
      end
    end
  end

  // Monitor for the GAP=0 instance
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      g0 = {j0, f0, b0, d0};
      if (g0 !== 4'b0000) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL mon_gap0 unexpected output jfbd=%b required none t=%0t", g0, $time);
        end else begin
          e0 = q0.pop_front();
          if (g0 !== e0) begin
            errors++;
            $display("FAIL mon_gap0 jfbd=%b required %b t=%0t", g0, e0, $time);
          end
        end
      end
    end
  end

  // Queue the per-cycle words of a transfer, then the done word
  task automatic push_exp(input int which, input string s);
    logic [3:0] e;
    byte        c;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (c == 8'd49)      e = 4'b1110;
      else if (c == 8'd48) e = 4'b0110;
      else                 e = 4'b0010;
      if (which == 2) q2.push_back(e); else q0.push_back(e);
    end
    if (which == 2) q2.push_back(4'b0001); else q0.push_back(4'b0001);
  endtask

  // One-cycle start pulse; returns 1ns after the sampling edge
  task automatic send(input int which, input logic [W-1:0] p, input logic [3:0] n,
                      input string exp_s);
    @(posedge clk);
    #1;
    push_exp(which, exp_s);
    if (which == 2) begin start2 = 1'b1; pat2 = p; cnt2 = n; end
    else            begin start0 = 1'b1; pat0 = p; cnt0 = n; end
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start0 = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty, then a few quiet cycles
  task automatic drain(input int which, input string name);
    int left;
    for (int k = 0; k < 300; k++) begin
      left = (which == 2) ? q2.size() : q0.size();
      if (left == 0) break;
      @(posedge clk);
    end
    left = (which == 2) ? q2.size() : q0.size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL drain_%s entries_left=%0d required 0", name, left);
      if (which == 2) q2.delete(); else q0.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic check_zero(input string name, input logic [3:0] got);
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL %s jfbd=%b required 0000", name, got);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start2 = 1'b0; start0 = 1'b0;
    pat2   = '0;   pat0   = '0;
    cnt2   = '0;   cnt0   = '0;
    #1 rst = 1'b0;
    #2;
    check_zero("reset_gap2", {j2, f2, b2, d2});
    check_zero("reset_gap0", {j0, f0, b0, d0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single repetition
    send(2, 5'b10010, 4'd1, "10010");
    drain(2, "single");

    // Three repetitions with two-bit gaps
    send(2, 5'b10010, 4'd3, "10010__10010__10010");
    drain(2, "rep3_gap2");

    // Back-to-back repetitions without a bubble
    send(0, 5'b10010, 4'd2, "1001010010");
    drain(0, "rep2_gap0");
    send(0, 5'b11011, 4'd3, "110111101111011");
    drain(0, "rep3_gap0");

    // Zero count: done only
    send(2, 5'b10010, 4'd0, "");
    drain(2, "count0_gap2");
    send(0, 5'b11111, 4'd0, "");
    drain(0, "count0_gap0");

    // Start and new pattern while busy must be ignored
    send(2, 5'b10010, 4'd2, "10010__10010");
    repeat (2) @(posedge clk);
    #1 start2 = 1'b1; pat2 = 5'b11111; cnt2 = 4'd3;
    repeat (3) @(posedge clk);
    #1 start2 = 1'b0;
    repeat (5) @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    drain(2, "start_while_busy");

    // Start held through the last bit and the done cycle is ignored
    send(2, 5'b01101, 4'd1, "01101");
    repeat (4) @(posedge clk);
    #1 start2 = 1'b1; pat2 = 5'b11111; cnt2 = 4'd1;
    repeat (2) @(posedge clk);
    #1 start2 = 1'b0;
    drain(2, "start_in_done");

    // Asynchronous reset during the third bit of a two-repetition send
    send(2, 5'b10110, 4'd2, "10110__10110");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_zero("async_reset_midframe", {j2, f2, b2, d2});
    q2.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    send(2, 5'b10010, 4'd1, "10010");
    drain(2, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_tx

`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the generator side of the team's serial sequence-detector interface. Emits a WIDTH-bit pattern MSB-first on a 1-bit serial line j, repeated a requested number of times, separated by programmable idle-zero gaps. Drives detector DUTs in system benches and on-chip self-test; Moore-style, all outputs registered.

Parameters:
WIDTH, 5, pattern length in bits (2..16)
GAP, 2, idle '0' bits inserted between repetitions (0..15); GAP=0 gives back-to-back patterns
CNT_W, 4, width of repetition count input

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
pattern  input  WIDTH  pattern to send; latched on accepted start
count  input  CNT_W  number of repetitions; latched on accepted start
j  output  1  serial data out, MSB first
frame  output  1  high during every cycle a pattern bit is on j
busy  output  1  high from cycle after accepted start until DONE ends
done  output  1  one-cycle pulse after last bit/zero-count request

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, j=0, frame=0, busy=0, done=0, shift reg, bit and gap counters, rep counter cleared. Release synchronous to next edge.
- States: IDLE, SEND, GAP, DONE. Encoding in shared package.
- IDLE: j=0, frame=0, busy=0. Edge with start=1: latch pattern into shift reg, count into rep counter.
  - count!=0 -> SEND; at that same edge j<=pattern[WIDTH-1], frame<=1, busy<=1 (first bit visible one cycle after start sampled).
  - count==0 -> DONE directly; j stays 0, frame 0.
- SEND: each edge shifts left, j<=next bit; exactly WIDTH cycles with frame=1. After last bit: decrement rep counter.
  - reps remain and GAP>0 -> GAP; j<=0, frame<=0.
  - reps remain and GAP==0 -> reload shift reg from latched pattern, stay SEND; j<=pattern MSB with no bubble.
  - no reps remain -> DONE; j<=0, frame<=0.
- GAP: exactly GAP cycles of j=0, frame=0, busy=1; then reload pattern, SEND.
- DONE: one cycle; done=1, busy=0, j=0; next edge -> IDLE. Start during DONE ignored.
- start while busy: ignored; pattern/count changes while busy have no effect (latched copy used).
- Total busy cycles for count=N>0: N*WIDTH + (N-1)*GAP; done asserts the cycle after.
- Rep counter width CNT_W; max count 2^CNT_W-1, no wrap.
- Reset mid-frame: j drops to 0 immediately (async), no done pulse, request lost.

Decomposition:
- Package seq_tx_pkg: state enum (IDLE, SEND, GAP, DONE), default pattern constant 5'b10010, GAP default.
- One natural sub-module: seq_tx_shifter (loadable WIDTH-bit MSB-first shift reg with bit counter, last_bit flag). FSM and counters in top.

Test Plan:
- Reset then start=1 one cycle, pattern=10010, count=1 -> j over next 5 cycles 1,0,0,1,0, frame=1 those 5 cycles, done pulse cycle 6, busy low after.
- pattern=10010, count=3, GAP=2 -> j = 10010 00 10010 00 10010 (19 busy cycles), frame high only on pattern bits, single done.
- GAP=0 build, pattern=10010, count=2 -> j = 1001010010 contiguous, frame continuously high 10 cycles.
- count=0 with start -> no frame, j stays 0, done pulses exactly one cycle after start sampled.
- start re-asserted and pattern changed to 11111 mid-transmission -> ignored; stream continues with 10010, no extra repetitions.
- rst pulled low during 3rd bit of count=2 send -> j, frame, busy go 0 without clock edge; after release state IDLE, no done; new start works normally.
